// File: rtl/w21_col_mac.sv
// Column dot product: streams DEPTH input elements against ROM weights, accumulates a 48-bit signed sum.
// Latency: y_valid rises 2 edges after the edge that accepts the last element.
// Backpressure: x_ready only in RUN, and gaps in x_valid stall the address; the result is held until y_ready.
module w21_col_mac #(
  parameter int DEPTH  = 300,
  parameter int ADDR_W = 9,
  parameter int W_W    = 21,
  parameter int X_W    = 16,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              x_valid,
  input  logic [X_W-1:0]    x_data,
  output logic              x_ready,
  output logic [ADDR_W-1:0] adrs_clm,
  input  logic [W_W-1:0]    w_in,
  output logic              y_valid,
  output logic [ACC_W-1:0]  y_data,
  input  logic              y_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int P_W = X_W + W_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t                  state, state_nxt;
  logic                    accept;
  logic signed [P_W-1:0]   mult;
  logic signed [P_W-1:0]   prod;
  logic                    prod_vld;
  logic signed [ACC_W-1:0] acc;

  assign accept = x_valid && (state == RUN);
  // Size casts of signed operands sign-extend, giving a full-width signed product.
  assign mult   = P_W'($signed(x_data)) * P_W'($signed(w_in));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && adrs_clm == LAST) state_nxt = DRAIN;
      // Leave only once the last product has been folded into acc.
      DRAIN:   if (!prod_vld) state_nxt = DONE;
      DONE:    if (y_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_ready = (state == RUN);
    y_valid = (state == DONE);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adrs_clm <= '0;
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      y_data   <= '0;
    end else begin
      if (state == IDLE && start) begin
        adrs_clm <= '0;
        acc      <= '0;
      end else begin
        if (accept) adrs_clm <= (adrs_clm == LAST) ? '0 : adrs_clm + ADDR_W'(1);
        if (prod_vld) acc <= acc + ACC_W'(prod);
      end
      prod_vld <= accept;
      if (accept) prod <= mult;
      if (state == DRAIN && !prod_vld) y_data <= acc;
    end
  end

endmodule
